fwd_hazard_unit: RTL and testbench

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_unit.sv | 138 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//   Tracks the EX, MEM and WB occupants of a 5-stage pipeline and produces
//   operand forwarding selects plus a load-use stall request.
//
// Ports
//   clk           single clock, all state updates on rising edge
//   rst_n         synchronous active-low reset
//   id_valid      decode-stage instruction present
//   id_rs1/rs2    decode-stage source registers
//   id_rd         decode-stage destination register
//   id_reg_write  decode instruction writes id_rd
//   id_mem_read   decode instruction is a load
//   flush         squash the instruction entering EX
//   hold          global pipeline freeze
//   fwd_a/fwd_b   forwarding selects (0 regfile, 1 EX/MEM, 2 MEM/WB, 3 zero),
//                 registered so they line up with the instruction in EX
//   stall         combinational load-use stall request
//   ex_valid      EX slot holds a real instruction
//   stall_cnt     saturating count of stall cycles taken
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  input  logic              hold,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall,
  output logic              ex_valid,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } slot_t;

  slot_t             ex_q, ex_d;
  slot_t             mem_q, mem_d;
  slot_t             wb_q, wb_d;
  logic [1:0]        fwd_a_q, fwd_a_d;
  logic [1:0]        fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              stall_c;
  logic              bubble;
  logic [REG_AW-1:0] rs_sel [2];
  logic [1:0]        code   [2];

  // Load in EX whose destination is read by decode; flush wins because the
  // decode instruction is being squashed anyway.
  always_comb begin
    stall_c = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
              ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2)) && !flush;
  end

  assign bubble    = flush || stall_c || !id_valid;
  assign rs_sel[0] = id_rs1;
  assign rs_sel[1] = id_rs2;

  // Forwarding selects look at the slots as they are before the edge: the
  // current EX occupant becomes EX/MEM, the current MEM occupant MEM/WB.
  for (genvar gi = 0; gi < 2; gi++) begin : g_code
    always_comb begin
      code[gi] = 2'd0;
      if (rs_sel[gi] == '0)
        code[gi] = 2'd3;
      else if (ex_q.valid && ex_q.reg_write && (ex_q.rd == rs_sel[gi]))
        code[gi] = 2'd1;
      else if (mem_q.valid && mem_q.reg_write && (mem_q.rd == rs_sel[gi]))
        code[gi] = 2'd2;
    end
  end

  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_cnt_d = stall_cnt_q;
    if (!hold) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (bubble) begin
        ex_d    = '0;
        fwd_a_d = 2'd0;
        fwd_b_d = 2'd0;
      end else begin
        ex_d.valid     = 1'b1;
        ex_d.rd        = id_rd;
        ex_d.reg_write = id_reg_write;
        ex_d.mem_read  = id_mem_read;
        fwd_a_d        = code[0];
        fwd_b_d        = code[1];
      end
      if (stall_c && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      fwd_a_q     <= 2'd0;
      fwd_b_q     <= 2'd0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall     = stall_c;
  assign ex_valid  = ex_q.valid;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
//   Directed stimulus against a small pipeline-history model. Every cycle the
//   DUT outputs are compared with the model; literal expectations at the key
//   points of each scenario pin the model itself.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  localparam int REG_AW  = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_reg_write, id_mem_read;
  logic              flush, hold;
  logic [1:0]        fwd_a, fwd_b;
  logic              stall, ex_valid;
  logic [CNT_W-1:0]  stall_cnt;

  fwd_hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .hold(hold),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall),
    .ex_valid(ex_valid), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Model: pipe[0] is the instruction in EX, pipe[1] in MEM, pipe[2] in WB.
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
  } mslot_t;

  mslot_t pipe [3];
  int     m_fa, m_fb, m_cnt;
  int     errors = 0;
  int     checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest in-flight writer of rs wins; x0 always reads as the zero constant.
  function automatic int m_code(input bit [4:0] rs);
    if (rs == 0) return 3;
    for (int k = 0; k < 2; k++)
      if (pipe[k].v && pipe[k].rw && pipe[k].rd == rs) return k + 1;
    return 0;
  endfunction

  function automatic bit m_stall();
    return id_valid && pipe[0].v && pipe[0].mr && pipe[0].rd != 0 &&
           (pipe[0].rd == id_rs1 || pipe[0].rd == id_rs2) && !flush;
  endfunction

  task automatic drive(input bit r, input bit v, input int rs1, input int rs2,
                       input int rd, input bit rw, input bit mr,
                       input bit fl, input bit hd);
    rst_n = r; id_valid = v;
    id_rs1 = REG_AW'(rs1); id_rs2 = REG_AW'(rs2); id_rd = REG_AW'(rd);
    id_reg_write = rw; id_mem_read = mr; flush = fl; hold = hd;
  endtask

  // Apply inputs for this cycle and compare every output against the model.
  task automatic apply(input bit r, input bit v, input int rs1, input int rs2,
                       input int rd, input bit rw, input bit mr,
                       input bit fl, input bit hd);
    drive(r, v, rs1, rs2, rd, rw, mr, fl, hd);
    #1;
    check("model_fwd_a", int'(fwd_a), m_fa);
    check("model_fwd_b", int'(fwd_b), m_fb);
    check("model_stall", int'(stall), int'(m_stall()));
    check("model_ex_valid", int'(ex_valid), int'(pipe[0].v));
    check("model_stall_cnt", int'(stall_cnt), m_cnt);
  endtask

  task automatic instr(input int rs1, input int rs2, input int rd,
                       input bit rw, input bit mr);
    apply(1'b1, 1'b1, rs1, rs2, rd, rw, mr, 1'b0, 1'b0);
  endtask

  task automatic idle();
    apply(1'b1, 1'b0, 1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    mslot_t n0;
    bit     s, issue;
    s = m_stall();
    @(posedge clk);
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0};
      m_fa = 0; m_fb = 0; m_cnt = 0;
    end else if (!hold) begin
      issue = id_valid && !flush && !s;
      n0    = issue ? '{1, id_rd, id_reg_write, id_mem_read} : '{0, 0, 0, 0};
      m_fa  = issue ? m_code(id_rs1) : 0;
      m_fb  = issue ? m_code(id_rs2) : 0;
      if (s && m_cnt < CNT_MAX) m_cnt++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = n0;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) begin idle(); tick(); end
  endtask

  initial begin
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    tick();
    tick();

    // Reset state
    idle();
    check("rst_fwd_a", fwd_a, 0);
    check("rst_fwd_b", fwd_b, 0);
    check("rst_ex_valid", ex_valid, 0);
    check("rst_stall_cnt", stall_cnt, 0);

    // Back-to-back EX/MEM forward
    instr(1, 2, 3, 1, 0); tick();
    instr(3, 6, 8, 1, 0);
    check("b2b_stall", stall, 0);
    tick();
    idle();
    check("b2b_fwd_a", fwd_a, 1);
    check("b2b_fwd_b", fwd_b, 0);
    check("b2b_ex_valid", ex_valid, 1);
    tick(); drain();

    // MEM/WB forward across one independent instruction
    instr(1, 2, 5, 1, 0); tick();
    instr(1, 2, 9, 1, 0); tick();
    instr(10, 5, 11, 1, 0); tick();
    idle();
    check("memwb_fwd_b", fwd_b, 2);
    check("memwb_fwd_a", fwd_a, 0);
    tick(); drain();

    // Load-use: one stall, bubble, reader re-issued with MEM/WB forward
    instr(1, 2, 7, 1, 1); tick();
    instr(7, 1, 12, 1, 0);
    check("lu_stall", stall, 1);
    check("lu_cnt_before", stall_cnt, 0);
    tick();
    instr(7, 1, 12, 1, 0);
    check("lu_stall_gone", stall, 0);
    check("lu_bubble", ex_valid, 0);
    check("lu_cnt_after", stall_cnt, 1);
    tick();
    idle();
    check("lu_fwd_a", fwd_a, 2);
    check("lu_reissue_valid", ex_valid, 1);
    tick(); drain();

    // EX/MEM beats MEM/WB; x0 gives the zero constant
    instr(1, 2, 4, 1, 0); tick();
    instr(1, 2, 4, 1, 0); tick();
    instr(4, 0, 13, 1, 0); tick();
    idle();
    check("prio_fwd_a", fwd_a, 1);
    check("prio_fwd_b", fwd_b, 3);
    tick();
    instr(1, 2, 0, 1, 0); tick();
    instr(0, 1, 14, 1, 0); tick();
    idle();
    check("x0_fwd_a", fwd_a, 3);
    tick(); drain();

    // Flush beats load-use stall
    instr(1, 2, 7, 1, 1); tick();
    apply(1'b1, 1'b1, 7, 1, 12, 1'b1, 1'b0, 1'b1, 1'b0);
    check("flush_stall", stall, 0);
    tick();
    idle();
    check("flush_bubble", ex_valid, 0);
    check("flush_cnt", stall_cnt, 1);
    tick(); drain();

    // Hold freezes outputs while stall stays combinational
    instr(1, 2, 3, 1, 0); tick();
    instr(3, 5, 7, 1, 1); tick();
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 1'b1, 7, 1, 15, 1'b1, 1'b0, 1'b0, 1'b1);
      check("hold_fwd_a", fwd_a, 1);
      check("hold_ex_valid", ex_valid, 1);
      check("hold_stall", stall, 1);
      check("hold_cnt", stall_cnt, 1);
      tick();
    end
    instr(7, 1, 15, 1, 0); tick();
    idle();
    check("hold_release_cnt", stall_cnt, 2);
    tick(); drain();

    // Saturation of the stall counter
    for (int k = 0; k < CNT_MAX + 2; k++) begin
      instr(1, 2, 7, 1, 1); tick();
      instr(1, 7, 16, 1, 0); tick();
      instr(1, 7, 16, 1, 0); tick();
    end
    idle();
    check("sat_cnt", stall_cnt, CNT_MAX);
    tick();

    // Reset in the middle of a load-use stall
    instr(1, 2, 7, 1, 1); tick();
    apply(1'b0, 1'b1, 7, 1, 17, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rstmid_stall_pre", stall, 1);
    tick();
    instr(7, 1, 17, 1, 0);
    check("rstmid_stall", stall, 0);
    check("rstmid_fwd_a", fwd_a, 0);
    check("rstmid_fwd_b", fwd_b, 0);
    check("rstmid_ex_valid", ex_valid, 0);
    check("rstmid_cnt", stall_cnt, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
